// File: rtl/clkdiv_ctrl_if.sv
// Ratio configuration handshake between a controller and clkdiv_ctrl.
// A ratio moves when cfg_valid and cfg_ready are both high on a rising clock edge.
// The requester holds cfg_valid/cfg_div while cfg_ready is low.
interface clkdiv_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             cfg_valid;
    logic [WIDTH-1:0] cfg_div;
    logic             cfg_ready;

    modport master (
        output cfg_valid,
        output cfg_div,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        output cfg_ready
    );
endinterface

// File: rtl/clkdiv_ctrl.sv
// Programmable clock divider: square wave clock_by_n plus end-of-period tick, ratio changes land on period boundaries.
// Latency: start/stop/ratio act on the next edge; a ratio accepted while running applies after the current period's tick.
// Backpressure: cfg_ready drops while a ratio is pending (PEND) or a soft stop drains (STOPPING).
// Optional: define CLKDIV_CTRL_SOFT_STOP_EN so that stop lets the current period finish before going idle.
module clkdiv_ctrl #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    clkdiv_ctrl_if.slave     cfg,
    output logic             clock_by_n,
    output logic             tick,
    output logic             running,
    output logic [WIDTH-1:0] cur_div
);

`ifdef CLKDIV_CTRL_SOFT_STOP_EN
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        PEND     = 2'd2,
        STOPPING = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;
`endif

    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] DIV_MIN = WIDTH'(2);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] cur_div_nxt;
    logic [WIDTH-1:0] shadow, shadow_nxt;
    logic             clock_by_n_nxt;

    logic             xfer;
    logic [WIDTH-1:0] cfg_coerced;
    logic             last;
    logic [WIDTH-1:0] cnt_inc;

    // Ratios below 2 cannot produce a square wave, so they are clamped on acceptance.
    assign cfg_coerced   = (cfg.cfg_div < DIV_MIN) ? DIV_MIN : cfg.cfg_div;
    assign cfg.cfg_ready = (state == IDLE) || (state == RUN);
    assign xfer          = cfg.cfg_valid && cfg.cfg_ready;
    assign last          = (cnt == cur_div - WIDTH'(1));
    assign cnt_inc       = last ? '0 : cnt + WIDTH'(1);
    assign running       = (state != IDLE);
    assign tick          = running && last;

    // Next-state, counter and ratio selection; ratio changes only ever take effect at a period boundary or on going idle.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        cur_div_nxt = cur_div;
        shadow_nxt  = shadow;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (xfer) begin
                    cur_div_nxt = cfg_coerced;
                end
                if (start && !stop) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                cnt_nxt = cnt_inc;
                if (stop) begin
`ifdef CLKDIV_CTRL_SOFT_STOP_EN
                    // Remember the ratio to apply once the final period has drained.
                    shadow_nxt = xfer ? cfg_coerced : cur_div;
                    if (last) begin
                        state_nxt   = IDLE;
                        cnt_nxt     = '0;
                        cur_div_nxt = xfer ? cfg_coerced : cur_div;
                    end else begin
                        state_nxt = STOPPING;
                    end
`else
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    if (xfer) begin
                        cur_div_nxt = cfg_coerced;
                    end
`endif
                end else if (xfer) begin
                    shadow_nxt = cfg_coerced;
                    state_nxt  = PEND;
                end
            end
            PEND: begin
                cnt_nxt = cnt_inc;
                if (stop) begin
`ifdef CLKDIV_CTRL_SOFT_STOP_EN
                    if (last) begin
                        state_nxt   = IDLE;
                        cnt_nxt     = '0;
                        cur_div_nxt = shadow;
                    end else begin
                        state_nxt = STOPPING;
                    end
`else
                    state_nxt   = IDLE;
                    cnt_nxt     = '0;
                    cur_div_nxt = shadow;
`endif
                end else if (last) begin
                    state_nxt   = RUN;
                    cur_div_nxt = shadow;
                end
            end
`ifdef CLKDIV_CTRL_SOFT_STOP_EN
            STOPPING: begin
                cnt_nxt = cnt_inc;
                if (last) begin
                    state_nxt   = IDLE;
                    cur_div_nxt = shadow;
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
        // The output wave is registered, so it is computed from the values the flops are about to take.
        clock_by_n_nxt = (state_nxt != IDLE) && (cnt_nxt < (cur_div_nxt >> 1));
    end

    // State, counter, ratio registers and the registered divided clock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            cur_div    <= DIV_RST;
            shadow     <= DIV_RST;
            clock_by_n <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            cur_div    <= cur_div_nxt;
            shadow     <= shadow_nxt;
            clock_by_n <= clock_by_n_nxt;
        end
    end

endmodule

// File: doc/clkdiv_ctrl.md
CLKDIV_CTRL -- requirements
Module: clkdiv_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, width of ratio and counter.
REQ-002 SHALL have parameter DEFAULT_DIV, default 8, divide ratio loaded at reset.
REQ-003 SHALL have port clock  input  1  sole clock; all flops rise-edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  level; begins division from IDLE.
REQ-006 SHALL have port stop  input  1  level; ends division.
REQ-007 SHALL have port cfg_valid  input  1  new-ratio request.
REQ-008 SHALL have port cfg_div  input  WIDTH  requested ratio N.
REQ-009 SHALL have port cfg_ready  output  1  ratio can be accepted this cycle.
REQ-010 SHALL have port clock_by_n  output  1  divided square wave, flop-driven.
REQ-011 SHALL have port tick  output  1  one-cycle pulse on the last cycle of each period.
REQ-012 SHALL have port running  output  1  high in RUN, PEND, STOPPING.
REQ-013 SHALL have port cur_div  output  WIDTH  ratio currently applied.

Function
REQ-014 SHALL implement states IDLE, RUN, PEND, and STOPPING (STOPPING only per REQ-028).
REQ-015 SHALL keep counter cnt in 0..cur_div-1, incrementing each RUN/PEND/STOPPING cycle and wrapping from cur_div-1 to 0.
REQ-016 SHALL assert tick exactly in cycles where running=1 and cnt==cur_div-1.
REQ-017 SHALL drive clock_by_n=1 when running=1 and cnt<floor(cur_div/2), else 0; for odd N the high phase is one cycle shorter than the low phase.
REQ-018 SHALL coerce any cfg_div below 2 to 2 on acceptance.
REQ-019 SHALL transfer a ratio when cfg_valid=1 and cfg_ready=1 in the same cycle; cfg_ready=1 in IDLE and RUN, 0 in PEND and STOPPING.
REQ-020 SHALL write an accepted ratio to cur_div on the next edge when in IDLE.
REQ-021 SHALL, on a transfer in RUN, hold the ratio in a shadow register and enter PEND, then at the tick cycle load cur_div from shadow, set cnt=0, return to RUN; no period is truncated.
REQ-022 SHALL move IDLE->RUN one edge after start=1 with stop=0, cnt=0; first tick at cur_div cycles after entry.
REQ-023 SHALL ignore start outside IDLE; stop has priority over simultaneous start.
REQ-024 SHALL, when a transfer and stop coincide in RUN, apply the ratio to cur_div on entry to IDLE.
REQ-025 SHALL, on stop in PEND, apply the shadow ratio to cur_div on entry to IDLE.

Reset
REQ-026 SHALL, on reset=1, immediately and regardless of clock: state=IDLE, cnt=0, cur_div=DEFAULT_DIV, shadow=DEFAULT_DIV, clock_by_n=0, tick=0, running=0, cfg_ready=1 after release.
REQ-027 SHALL discard any pending ratio and in-progress period on reset mid-operation; no tick is produced by reset.

Configuration
REQ-028 SHALL, with CLKDIV_CTRL_SOFT_STOP_EN defined, route stop in RUN/PEND to STOPPING, continue counting, and enter IDLE after the tick cycle, so the final period completes.
REQ-029 SHALL, without CLKDIV_CTRL_SOFT_STOP_EN, enter IDLE one edge after stop=1, cnt=0, clock_by_n=0, no tick; STOPPING is not instantiated.

Verification
REQ-030 SHALL cover: reset, start pulse, N=8 -> clock_by_n high 4 / low 4 cycles, tick every 8th cycle, cur_div=8.
REQ-031 SHALL cover: in RUN at N=8, cfg_div=5 accepted at cnt=2 -> cfg_ready=0 until tick at cnt=7, then periods of 5 (high 2, low 3).
REQ-032 SHALL cover: cfg_div=0 and cfg_div=1 in IDLE -> cur_div=2, clock_by_n toggles every cycle after start.
REQ-033 SHALL cover: stop at cnt=3, N=8 -> macro off: running=0 next cycle, no tick; macro on: tick at cnt=7, then running=0.
REQ-034 SHALL cover: reset asserted mid-period between edges at N=6 with PEND active -> outputs 0 immediately, cur_div=8 after release.
REQ-035 SHALL cover: start and stop both high in IDLE -> state stays IDLE, running=0.
